imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate extender.
- Decodes the immediate from instr[31:7] per immSrc and sign-extends it to XLEN.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between the decode stage and the execute-stage operand mux of the pipelined core. Also flags and counts illegal immSrc encodings.

Parameters:
- XLEN, 32, result width; legal values 32 or 64; the sign bit instr[31] fills all upper bits.
- ERR_CNT_W, 16, width of the saturating illegal-encoding counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- inValid  in  1  upstream has an instruction.
- inReady  out  1  block can accept; high when the skid entry is empty.
- instr  in  25  instruction bits [31:7].
- immSrc  in  3  immediate format select.
- outValid  out  1  immExt/immErr valid.
- outReady  in  1  downstream accepts.
- immExt  out  XLEN  extended immediate.
- immErr  out  1  the presented result came from an illegal immSrc.
- errCount  out  ERR_CNT_W  number of accepted illegal encodings, saturating.

Behaviour:
- Encodings: 000 I, 001 S, 010 B, 011 J, 100 U.
  - I: {sx, instr[31:20]}
  - S: {sx, instr[31:25], instr[11:7]}
  - B: {sx, instr[7], instr[30:25], instr[11:8], 0}
  - J: {sx, instr[19:12], instr[20], instr[30:21], 0}
  - U: {sx, instr[31:12], 12'b0}
  - sx = instr[31] replicated to XLEN. For XLEN=32, U carries no upper fill.
- Illegal encodings (101, 110, 111; 101 is legal with the optional feature enabled) produce immExt=0 and immErr=1.
- Transfers: an input transfer occurs when inValid & inReady; an output transfer occurs when outValid & outReady.
- Main output register: loads the decoded input on an input transfer when it is empty or being drained in the same cycle. Latency is 1 cycle, giving 1 result per cycle throughput when outReady stays high.
- Skid register: captures the input when an input transfer happens while the main register is full and not draining. inReady then deasserts on the next cycle.
- When the main register drains and the skid is full, the skid moves into the main register; the skid frees in the same cycle.
- Ordering is strictly FIFO; no result is dropped or duplicated.
- Occupancy states: EMPTY, ONE (main full), TWO (main+skid full). Transitions:
  - EMPTY→ONE on input transfer.
  - ONE→TWO on input transfer without output transfer.
  - ONE→EMPTY on output transfer without input transfer.
  - TWO→ONE on output transfer.
  - Simultaneous input and output transfer in ONE stays in ONE.
- Register contents are held stable while outValid=1 and outReady=0.
- errCount increments by 1 per input transfer with an illegal immSrc and saturates at all-ones, never wrapping. Inputs that are not accepted do not count.
- Reset, asynchronous and allowed at any time including mid-stall: state→EMPTY, outValid=0, inReady=1, immExt=0, immErr=0, errCount=0. In-flight results are discarded.
- inReady depends on registered state only; there is no combinational path from outReady to inReady.

Optional Feature:
- Macro: IMM_ZICSR_EN.
- Defined: immSrc 101 is legal and yields the CSR zimm, {zero-extended, instr[19:15]}. It does not set immErr and is not counted.
- Undefined: 101 is illegal as above.

Decomposition:
- Package imm_pkg holds the immSrc localparams (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z), the occupancy state encoding, and an XLEN legality check.
- Sub-module imm_decode: combinational format decode with XLEN, immExt and illegal flag. It is instantiated once, and the pipeline registers live in the top module.

Test Plan:
- XLEN=32, immSrc=000, instr[31:7] giving I-imm 0xFFF, outReady=1 → immExt=0xFFFFFFFF one cycle later, immErr=0.
- XLEN=64, immSrc=100, instr[31]=1, instr[30:12]=0 → immExt=0xFFFFFFFF80000000.
- Back-to-back B and J inputs with outReady=0 for 3 cycles: inReady falls after 2 accepts. Release outReady → results appear in order B then J, with nothing lost.
- immSrc=110 accepted twice, plus one not accepted while inReady=0 → immErr=1 on both results, errCount=2. With ERR_CNT_W=2 and 5 illegal inputs → errCount=3.
- Assert reset while in state TWO → outValid=0, inReady=1, errCount=0 immediately, without waiting for a clock edge.
- IMM_ZICSR_EN defined, immSrc=101, instr[19:15]=5'h1F → immExt=0x1F, immErr=0. Undefined → immExt=0, immErr=1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate extender:
// immSrc encodings, occupancy states and an XLEN legality check.
package imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate format decode and sign extension to XLEN.
// IMM_ZICSR_EN makes immSrc 101 a legal CSR zimm instead of illegal.
module imm_decode #(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr,
    input  logic [2:0]      immSrc,
    output logic [XLEN-1:0] immExt,
    output logic            illegal
);
    import imm_pkg::*;

    logic [31:7]        ins;
    logic               s;
    logic signed [31:0] w32;

    assign ins = instr;
    assign s   = ins[31];

    // Build the 32-bit immediate; the signed cast below fills any upper bits
    always_comb begin
        w32     = '0;
        illegal = 1'b0;
        unique case (1'b1)
            (immSrc == IMM_I): w32 = {{20{s}}, ins[31:20]};
            (immSrc == IMM_S): w32 = {{20{s}}, ins[31:25], ins[11:7]};
            (immSrc == IMM_B): w32 = {{20{s}}, ins[7], ins[30:25],
                                      ins[11:8], 1'b0};
            (immSrc == IMM_J): w32 = {{12{s}}, ins[19:12], ins[20],
                                      ins[30:21], 1'b0};
            (immSrc == IMM_U): w32 = {ins[31:12], 12'b0};
`ifdef IMM_ZICSR_EN
            (immSrc == IMM_Z): w32 = {27'b0, ins[19:15]};
`endif
            default:           illegal = 1'b1;
        endcase
    end

    assign immExt = XLEN'(w32);

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready and a 2-entry skid.
// IMM_ZICSR_EN enables immSrc 101 (CSR zimm) in the decoder.
module imm_extend_pipe #(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [24:0]          instr,
    input  logic [2:0]           immSrc,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [XLEN-1:0]      immExt,
    output logic                 immErr,
    output logic [ERR_CNT_W-1:0] errCount
);
    import imm_pkg::*;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    occ_t            state, stateNext;
    logic [XLEN-1:0] decExt, skidExt;
    logic            decIll, skidErr;
    logic            inXfer, outXfer;
    logic            loadMain, loadSkid, moveSkid;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (instr),
        .immSrc  (immSrc),
        .immExt  (decExt),
        .illegal (decIll)
    );

    assign inReady  = (state != OCC_TWO);
    assign outValid = (state != OCC_EMPTY);
    assign inXfer   = inValid & inReady;
    assign outXfer  = outValid & outReady;

    // Occupancy next-state and register load selects
    always_comb begin
        stateNext = state;
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        moveSkid  = 1'b0;
        unique case (state)
            OCC_EMPTY: begin
                if (inXfer) begin
                    stateNext = OCC_ONE;
                    loadMain  = 1'b1;
                end
            end
            OCC_ONE: begin
                if (inXfer && outXfer) begin
                    loadMain = 1'b1;
                end else if (inXfer) begin
                    stateNext = OCC_TWO;
                    loadSkid  = 1'b1;
                end else if (outXfer) begin
                    stateNext = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (outXfer) begin
                    stateNext = OCC_ONE;
                    moveSkid  = 1'b1;
                end
            end
            default: stateNext = OCC_EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= OCC_EMPTY;
        else       state <= stateNext;
    end

    // Main output and skid data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            immExt  <= '0;
            immErr  <= 1'b0;
            skidExt <= '0;
            skidErr <= 1'b0;
        end else begin
            if (loadMain) begin
                immExt <= decExt;
                immErr <= decIll;
            end else if (moveSkid) begin
                immExt <= skidExt;
                immErr <= skidErr;
            end
            if (loadSkid) begin
                skidExt <= decExt;
                skidErr <= decIll;
            end
        end
    end

    // Saturating count of accepted illegal encodings
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCount <= '0;
        end else if (inXfer && decIll && (errCount != '1)) begin
            errCount <= errCount + ERR_CNT_W'(1);
        end
    end

endmodule
